fifo_skew_seq: RTL

- Parametrised successor to the column-enable generator that feeds the MMU input FIFOs.
- Produces a diagonally skewed enable wavefront across WIDTH FIFO columns. Column k is enabled for exactly len cycles, starting k cycles after column 0.
- Adds programmable burst length, drain phase, stall, abort, and a start/busy/done handshake.
- Sits between the top-level controller and the FIFO bank in front of the systolic array.

---
 rtl/fifo_skew_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_skew_seq.sv
// ============================================================================
// Module   : fifo_skew_seq
// Purpose  : Diagonally skewed column-enable generator for the MMU input FIFOs.
//            The optional stall counter is compiled in by FIFO_SKEW_SEQ_STALL_CNT_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fifo_skew_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             stall,
  input  logic             abort,
  output logic [WIDTH-1:0] fifo_en,
  output logic             busy,
  output logic             done
`ifdef FIFO_SKEW_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_en, w_en_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_shift_one;
  logic [WIDTH-1:0] w_shift_zero;

  // A single column has nothing to shift into; the MSB always falls off.
  generate
    if (WIDTH == 1) begin : g_single
      assign w_shift_one  = 1'b1;
      assign w_shift_zero = 1'b0;
    end else begin : g_multi
      assign w_shift_one  = {r_en[WIDTH-2:0], 1'b1};
      assign w_shift_zero = {r_en[WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign w_accept = (r_state == IDLE) && start && !stall && !abort && (len != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_rem_nxt   = r_rem;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_en_nxt    = '0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_en_nxt    = WIDTH'(1);
            w_rem_nxt   = len - LEN_W'(1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = (len != LEN_W'(1)) ? FEED : DRAIN;
          end
        end
        FEED: begin
          if (!stall) begin
            w_en_nxt  = w_shift_one;
            w_rem_nxt = r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              w_state_nxt = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            w_en_nxt = w_shift_zero;
            if (w_shift_zero == '0) begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_en_nxt    = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_en    <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign fifo_en = r_en & {WIDTH{~stall}};
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef FIFO_SKEW_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_stall_cnt <= '0;
    end else if (r_busy && stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
